// File: rtl/align_lane_fifo.sv
// Per-lane word buffer for stream_align2: a register-array FIFO with a separate
// occupancy count, a sticky drop flag, and a combinational head.
module align_lane_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   lvl,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;

  logic full, wr_en, rd_en, drop;

  // A pop at full frees the head slot in the same cycle, so the push still lands.
  assign full  = (cnt_q == FULL_CNT);
  assign rd_en = pop & (cnt_q != '0) & ~clr;
  assign wr_en = push & (~full | rd_en) & ~clr;
  assign drop  = push & full & ~rd_en & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= din;
  end

  assign head = mem_q[rp_q];
  assign lvl  = cnt_q;
  assign ovf  = ovf_q;
endmodule

// File: rtl/stream_align2.sv
// Two-lane skew absorber: buffers lane A and lane B words and emits them as
// registered pairs once both lanes have a word available.
module stream_align2 #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     a_vld,
  input  logic [DW-1:0]            a_dat,
  input  logic                     b_vld,
  input  logic [DW-1:0]            b_dat,
  output logic                     o_vld,
  output logic [DW-1:0]            o_a,
  output logic [DW-1:0]            o_b,
  output logic [$clog2(DEPTH):0]   lvl_a,
  output logic [$clog2(DEPTH):0]   lvl_b,
  output logic                     ovf_a,
  output logic                     ovf_b
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] head_a, head_b;
  logic [AW:0]   lvl_a_w, lvl_b_w;
  logic          ne_a, ne_b, pop, emit, push_a, push_b;
  logic [DW-1:0] o_a_d, o_b_d;
  logic          o_vld_q;
  logic [DW-1:0] o_a_q, o_b_q;

  assign ne_a = (lvl_a_w != '0);
  assign ne_b = (lvl_b_w != '0);
  assign pop  = (ne_a | a_vld) & (ne_b | b_vld);
  assign emit = pop & ~clr;

  // An empty lane that pairs this cycle bypasses its word straight to the output.
  assign push_a = a_vld & (ne_a | ~pop);
  assign push_b = b_vld & (ne_b | ~pop);
  assign o_a_d  = ne_a ? head_a : a_dat;
  assign o_b_d  = ne_b ? head_b : b_dat;

  align_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_lane_a (
    .clk(clk), .rst(rst), .clr(clr), .push(push_a), .din(a_dat),
    .pop(pop), .head(head_a), .lvl(lvl_a_w), .ovf(ovf_a)
  );

  align_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_lane_b (
    .clk(clk), .rst(rst), .clr(clr), .push(push_b), .din(b_dat),
    .pop(pop), .head(head_b), .lvl(lvl_b_w), .ovf(ovf_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld_q <= 1'b0;
      o_a_q   <= '1;
      o_b_q   <= '1;
    end else begin
      o_vld_q <= emit;
      if (emit) begin
        o_a_q <= o_a_d;
        o_b_q <= o_b_d;
      end
    end
  end

  assign o_vld = o_vld_q;
  assign o_a   = o_a_q;
  assign o_b   = o_b_q;
  assign lvl_a = lvl_a_w;
  assign lvl_b = lvl_b_w;
endmodule

// File: tb/tb_stream_align2.sv
// Bench for stream_align2: a queue-based lane model feeds a pair scoreboard that
// is checked against the DUT every cycle.
module tb_stream_align2;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst, clr, a_vld, b_vld;
  logic [DW-1:0] a_dat, b_dat, o_a, o_b;
  logic o_vld, ovf_a, ovf_b;
  logic [$clog2(DEPTH):0] lvl_a, lvl_b;

  stream_align2 #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_vld(a_vld), .a_dat(a_dat), .b_vld(b_vld), .b_dat(b_dat),
    .o_vld(o_vld), .o_a(o_a), .o_b(o_b),
    .lvl_a(lvl_a), .lvl_b(lvl_b), .ovf_a(ovf_a), .ovf_b(ovf_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] qa[$], qb[$];
  logic [2*DW-1:0] sb[$];
  logic m_ovf_a, m_ovf_b;
  logic [DW-1:0] last_a, last_b;
  int peak_a;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); sb.delete();
    m_ovf_a = 1'b0; m_ovf_b = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, then check at the next negedge.
  task automatic step(input logic av, input logic [DW-1:0] ad,
                      input logic bv, input logic [DW-1:0] bd, input logic c);
    logic p;
    logic [DW-1:0] ea, eb;
    a_vld = av; a_dat = ad; b_vld = bv; b_dat = bd; clr = c;
    if (c) begin
      qa.delete(); qb.delete();
      m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else begin
      p = ((qa.size() != 0) || av) && ((qb.size() != 0) || bv);
      if (av) begin
        if (p || qa.size() < DEPTH) qa.push_back(ad); else m_ovf_a = 1'b1;
      end
      if (bv) begin
        if (p || qb.size() < DEPTH) qb.push_back(bd); else m_ovf_b = 1'b1;
      end
      if (p) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        sb.push_back({ea, eb});
      end
    end
    @(posedge clk);
    @(negedge clk);
    a_vld = 1'b0; b_vld = 1'b0; clr = 1'b0;
    check_eq("o_vld", o_vld, (sb.size() != 0));
    if (sb.size() != 0) {last_a, last_b} = sb.pop_front();
    check_eq("o_a", o_a, last_a);
    check_eq("o_b", o_b, last_b);
    check_eq("lvl_a", lvl_a, qa.size());
    check_eq("lvl_b", lvl_b, qb.size());
    check_eq("ovf_a", ovf_a, m_ovf_a);
    check_eq("ovf_b", ovf_b, m_ovf_b);
    if (int'(lvl_a) > peak_a) peak_a = int'(lvl_a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; a_vld = 1'b0; b_vld = 1'b0; a_dat = '0; b_dat = '0;
    model_clear();
    last_a = '1; last_b = '1;
    #1;
    check_eq("rst_o_vld", o_vld, 0);
    check_eq("rst_o_a", o_a, 8'hFF);
    check_eq("rst_o_b", o_b, 8'hFF);
    check_eq("rst_lvl_a", lvl_a, 0);
    check_eq("rst_ovf_a", ovf_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Same-cycle arrival
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    check_eq("t1_o_a", o_a, 8'h11);
    check_eq("t1_o_b", o_b, 8'h22);
    idle(1);

    // Skew of five words
    peak_a = 0;
    for (int c = 0; c < 15; c++)
      step(c < 10, DW'(c), c >= 5, DW'(c - 5), 1'b0);
    idle(2);
    check_eq("t2_peak_a", peak_a, 5);

    // Overflow on lane A
    for (int i = 0; i < 20; i++) step(1'b1, DW'(i), 1'b0, '0, 1'b0);
    check_eq("t3_lvl_full", lvl_a, 16);
    check_eq("t3_ovf", ovf_a, 1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, DW'(i), 1'b0);
    idle(1);
    check_eq("t3_lvl_drained", lvl_a, 0);

    // Full lane with simultaneous push and pop
    step(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h40 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h60 + i), 1'b1, DW'(8'h80 + i), 1'b0);
    check_eq("t6_lvl", lvl_a, 16);
    check_eq("t6_ovf", ovf_a, 0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, DW'(8'h90 + i), 1'b0);
    idle(1);

    // clr collision with lvl_b=3 and ovf_b=1
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, DW'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, '0, 1'b0);
    check_eq("t5_pre_lvl_b", lvl_b, 3);
    check_eq("t5_pre_ovf_b", ovf_b, 1);
    step(1'b1, 8'hEE, 1'b1, 8'hDD, 1'b1);
    check_eq("t5_lvl_b", lvl_b, 0);
    check_eq("t5_ovf_b", ovf_b, 0);
    check_eq("t5_o_vld", o_vld, 0);
    idle(1);

    // Asynchronous reset mid-stream with lvl_a=7
    for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h30 + i), 1'b0, '0, 1'b0);
    check_eq("t4_pre_lvl", lvl_a, 7);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_o_vld", o_vld, 0);
    check_eq("t4_o_a", o_a, 8'hFF);
    check_eq("t4_o_b", o_b, 8'hFF);
    check_eq("t4_lvl_a", lvl_a, 0);
    check_eq("t4_lvl_b", lvl_b, 0);
    model_clear();
    last_a = '1; last_b = '1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b0);
    check_eq("t4_pair_a", o_a, 8'h5A);
    check_eq("t4_pair_b", o_b, 8'hA5);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
